fifo_axis_reader: RTL and testbench



---
 rtl/fifo_axis_reader.sv | 114 +++++++++++
 tb/tb_fifo_axis_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_reader.sv
// Drains a first-word-fall-through packet FIFO into a registered AXI-stream master,
// truncating packets longer than MAXLEN bytes and discarding their remainder.
module fifo_axis_reader #(
  parameter int unsigned BW     = 64,
  parameter int unsigned LGB    = $clog2(BW / 8),
  parameter int unsigned MAXLEN = 2048
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_empty,
  input  logic [BW+LGB:0]   i_fifo_data,
  output logic              o_rd,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [BW-1:0]     M_DATA,
  output logic [LGB-1:0]    M_BYTES,
  output logic              M_LAST,
  output logic              M_ABORT,
  output logic [31:0]       o_pkts,
  output logic [15:0]       o_drops
);

  typedef enum logic [1:0] {StIdle, StPkt, StDrop} state_e;

  state_e          state_q, state_d;
  logic [16:0]     len_q, len_d;
  logic            valid_d, last_d, abort_d;
  logic [BW-1:0]   data_d;
  logic [LGB-1:0]  bytes_d;
  logic [31:0]     pkts_d;
  logic [15:0]     drops_d;

  logic [BW-1:0]   word_data;
  logic [LGB-1:0]  word_bytes;
  logic            word_last;
  logic [16:0]     beat_bytes;
  logic [16:0]     next_len;
  logic            over;
  logic            ld;

  assign word_data  = i_fifo_data[BW-1:0];
  assign word_bytes = i_fifo_data[BW+LGB-1:BW];
  assign word_last  = i_fifo_data[BW+LGB];

  // A zero byte field encodes a full word.
  assign beat_bytes = (word_bytes == '0) ? 17'(BW / 8) : 17'(word_bytes);
  assign next_len   = len_q + beat_bytes;
  assign over       = next_len > 17'(MAXLEN);

  assign ld   = !i_reset && !i_empty && (state_q != StDrop) && (!M_VALID || M_READY);
  assign o_rd = ld || (!i_reset && (state_q == StDrop) && !i_empty);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    valid_d = M_VALID;
    data_d  = M_DATA;
    bytes_d = M_BYTES;
    last_d  = M_LAST;
    abort_d = M_ABORT;
    pkts_d  = o_pkts;
    drops_d = o_drops;

    if (M_VALID && M_READY) begin
      valid_d = 1'b0;
      if (M_LAST && !M_ABORT) pkts_d = o_pkts + 32'd1;
    end

    if (ld) begin
      valid_d = 1'b1;
      data_d  = word_data;
      bytes_d = word_bytes;
      if (over) begin
        last_d  = 1'b1;
        abort_d = 1'b1;
        len_d   = '0;
        drops_d = o_drops + 16'd1;
        state_d = word_last ? StIdle : StDrop;
      end else begin
        last_d  = word_last;
        abort_d = 1'b0;
        len_d   = word_last ? 17'd0 : next_len;
        state_d = word_last ? StIdle : StPkt;
      end
    end else if ((state_q == StDrop) && !i_empty && word_last) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      M_VALID <= 1'b0;
      M_DATA  <= '0;
      M_BYTES <= '0;
      M_LAST  <= 1'b0;
      M_ABORT <= 1'b0;
      o_pkts  <= '0;
      o_drops <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      M_VALID <= valid_d;
      M_DATA  <= data_d;
      M_BYTES <= bytes_d;
      M_LAST  <= last_d;
      M_ABORT <= abort_d;
      o_pkts  <= pkts_d;
      o_drops <= drops_d;
    end
  end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader: a FIFO model feeds the DUT, expected beats are
// queued as words are issued and a monitor compares every accepted beat.
module tb_fifo_axis_reader;

  localparam int unsigned BW     = 64;
  localparam int unsigned LGB    = 3;
  localparam int unsigned MAXLEN = 64;
  localparam int unsigned WW     = BW + LGB + 1;

  typedef struct packed {
    logic [BW-1:0]  data;
    logic [LGB-1:0] bytes;
    logic           last;
    logic           abort;
  } beat_t;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_empty = 1'b1;
  logic [WW-1:0]     i_fifo_data = '0;
  logic              o_rd;
  logic              M_VALID;
  logic              M_READY = 1'b1;
  logic [BW-1:0]     M_DATA;
  logic [LGB-1:0]    M_BYTES;
  logic              M_LAST;
  logic              M_ABORT;
  logic [31:0]       o_pkts;
  logic [15:0]       o_drops;

  fifo_axis_reader #(.BW(BW), .MAXLEN(MAXLEN)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_empty     (i_empty),
    .i_fifo_data (i_fifo_data),
    .o_rd        (o_rd),
    .M_VALID     (M_VALID),
    .M_READY     (M_READY),
    .M_DATA      (M_DATA),
    .M_BYTES     (M_BYTES),
    .M_LAST      (M_LAST),
    .M_ABORT     (M_ABORT),
    .o_pkts      (o_pkts),
    .o_drops     (o_drops)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [WW-1:0] fifo_q[$];
  beat_t         exp_q[$];
  bit            toggle_ready = 1'b0;
  bit            stall_chk    = 1'b0;

  // Reference packet state carried across words so gapped packets are modelled.
  int unsigned   m_len  = 0;
  bit            m_drop = 1'b0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // FIFO model and M_READY driver: pops on o_rd seen mid-cycle, updates after the edge.
  initial begin
    bit rd_seen;
    forever begin
      @(negedge i_clk);
      rd_seen = o_rd;
      if (o_rd && i_empty) check("rd_while_empty", 1, 0);
      @(posedge i_clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      i_empty     = (fifo_q.size() == 0);
      i_fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      M_READY     = toggle_ready ? ~M_READY : 1'b1;
    end
  end

  // Monitor: compare each accepted beat, and check stalled beats stay put.
  initial begin
    beat_t e, prev;
    bit    prev_stall = 1'b0;
    forever begin
      @(negedge i_clk);
      if (prev_stall) begin
        check("stall_valid", 64'(M_VALID), 64'd1);
        check("stall_beat", 64'({M_DATA, M_BYTES, M_LAST, M_ABORT} != prev), 64'd0);
      end
      if (stall_chk && M_VALID && !M_READY) check("stall_rd", 64'(o_rd), 64'd0);
      if (M_VALID && M_READY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", M_DATA, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", M_DATA, e.data);
          check("beat_ctl", 64'({M_BYTES, M_LAST, M_ABORT}), 64'({e.bytes, e.last, e.abort}));
        end
      end
      prev_stall = M_VALID && !M_READY && !i_reset;
      prev       = {M_DATA, M_BYTES, M_LAST, M_ABORT};
    end
  end

  // Issue n words; the final one carries lb bytes and, if set, the last flag.
  task automatic send_words(input int n, input int lb, input bit last_at_end, input int pid);
    for (int i = 0; i < n; i++) begin
      logic [BW-1:0]  d;
      logic [LGB-1:0] b;
      logic           l;
      int unsigned    bb;
      d  = (64'(pid) << 32) | 64'(i) | 64'hA500_0000_0000_0000;
      b  = (i == n - 1) ? LGB'(lb) : '0;
      l  = (i == n - 1) && last_at_end;
      bb = (b == 0) ? BW / 8 : int'(b);
      fifo_q.push_back({l, b, d});
      if (m_drop) begin
        if (l) m_drop = 1'b0;
      end else if (m_len + bb > MAXLEN) begin
        exp_q.push_back('{data: d, bytes: b, last: 1'b1, abort: 1'b1});
        m_len  = 0;
        m_drop = !l;
      end else begin
        exp_q.push_back('{data: d, bytes: b, last: l, abort: 1'b0});
        m_len = l ? 0 : m_len + bb;
      end
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && cyc < 300) begin
      @(posedge i_clk);
      cyc++;
    end
    check("drain_timeout", 64'(cyc >= 300), 64'd0);
    repeat (3) @(posedge i_clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_valid", 64'(M_VALID), 64'd0);
    check("rst_data", M_DATA, 64'd0);
    check("rst_ctl", 64'({M_BYTES, M_LAST, M_ABORT}), 64'd0);
    check("rst_pkts", 64'(o_pkts), 64'd0);
    check("rst_drops", 64'(o_drops), 64'd0);
    @(posedge i_clk);
    #1 i_reset = 1'b0;

    // 3-word packet, 20 bytes.
    send_words(3, 4, 1'b1, 1);
    drain();
    check("t1_pkts", 64'(o_pkts), 64'd1);

    // Exactly MAXLEN bytes passes intact.
    send_words(8, 0, 1'b1, 2);
    drain();
    check("t2_pkts", 64'(o_pkts), 64'd2);
    check("t2_drops", 64'(o_drops), 64'd0);

    // 96 bytes: truncated at word 9, words 10..12 discarded, then a clean packet.
    send_words(12, 0, 1'b1, 3);
    send_words(1, 5, 1'b1, 4);
    drain();
    check("t3_pkts", 64'(o_pkts), 64'd3);
    check("t3_drops", 64'(o_drops), 64'd1);

    // Back-to-back single-word packets under toggling backpressure.
    toggle_ready = 1'b1;
    stall_chk    = 1'b1;
    for (int p = 0; p < 4; p++) send_words(1, p + 1, 1'b1, 10 + p);
    drain();
    toggle_ready = 1'b0;
    stall_chk    = 1'b0;
    drain();
    check("t4_pkts", 64'(o_pkts), 64'd7);

    // FIFO runs dry mid-packet; length accumulates across the gap.
    send_words(4, 0, 1'b0, 20);
    drain();
    repeat (5) @(posedge i_clk);
    send_words(4, 0, 1'b1, 21);
    drain();
    check("t5a_pkts", 64'(o_pkts), 64'd8);
    send_words(5, 0, 1'b0, 22);
    drain();
    repeat (5) @(posedge i_clk);
    send_words(4, 0, 1'b1, 23);
    drain();
    check("t5b_pkts", 64'(o_pkts), 64'd8);
    check("t5b_drops", 64'(o_drops), 64'd2);

    // Reset while discarding: 9 words without last leave the DUT in DROP.
    send_words(9, 0, 1'b0, 30);
    drain();
    check("t6_pre_drops", 64'(o_drops), 64'd3);
    @(posedge i_clk);
    #1 i_reset = 1'b1;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    check("t6_valid", 64'(M_VALID), 64'd0);
    check("t6_pkts", 64'(o_pkts), 64'd0);
    check("t6_drops", 64'(o_drops), 64'd0);
    m_len  = 0;
    m_drop = 1'b0;
    send_words(1, 2, 1'b1, 31);
    drain();
    check("t6_post_pkts", 64'(o_pkts), 64'd1);
    check("leftover_exp", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
